fir_seq_ctrl: RTL and testbench

FIR_SEQ_CTRL -- requirements
Module: fir_seq_ctrl

---
 rtl/fir_seq_ctrl_if.sv | 31 +++
 rtl/fir_seq_ctrl.sv | 179 +++++++++++++++++
 tb/tb_fir_seq_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_seq_ctrl_if.sv
// Handshake and memory/datapath control bundle between the FIR sequencer and its host/datapath.
interface fir_seq_ctrl_if;
    logic       sample_req;
    logic [6:0] ntaps;
    logic       cload;
    logic       cload_gnt;
    logic       sample_ack;
    logic       dmem_wr;
    logic [5:0] dmem_addr;
    logic [5:0] cmem_addr;
    logic       mul_en;
    logic       acc_en;
    logic       acc_clr;
    logic       norm_en;
    logic       valid;
    logic       busy;

    // Host / datapath side
    modport master (
        output sample_req, ntaps, cload,
        input  cload_gnt, sample_ack, dmem_wr, dmem_addr, cmem_addr,
               mul_en, acc_en, acc_clr, norm_en, valid, busy
    );

    // Sequencer side
    modport slave (
        input  sample_req, ntaps, cload,
        output cload_gnt, sample_ack, dmem_wr, dmem_addr, cmem_addr,
               mul_en, acc_en, acc_clr, norm_en, valid, busy
    );
endinterface

// File: rtl/fir_seq_ctrl.sv
// FIR sequencer: per-sample LOAD/MAC/DRAIN/NORM control over a 64-entry circular sample buffer.
// Optional macro FIR_SEQ_DROP_CNT_EN adds an 8-bit saturating counter of dropped sample requests.
module fir_seq_ctrl #(
    parameter int unsigned PIPE_LAT = 5
) (
    input  logic clk2,
    input  logic rst,
`ifdef FIR_SEQ_DROP_CNT_EN
    output logic [7:0] drop_cnt,
`endif
    fir_seq_ctrl_if.slave bus
);

    localparam int unsigned AW        = 6;
    localparam int unsigned NTAPS_MAX = 64;
    localparam logic [AW-1:0] DRAIN_LAST = AW'(PIPE_LAT - 1);
    localparam logic [AW-1:0] TAP_LAST   = AW'(NTAPS_MAX - 1);

    typedef enum logic [4:0] {
        IDLE  = 5'b00001,
        LOAD  = 5'b00010,
        MAC   = 5'b00100,
        DRAIN = 5'b01000,
        NORM  = 5'b10000
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] k_q, k_d;
    logic [AW-1:0] n_last_q, n_last_d;

    logic          sample_ack_d, dmem_wr_d, mul_en_d, norm_en_d, valid_d, busy_d, first_tap_d;
    logic [AW-1:0] dmem_addr_d, cmem_addr_d;

    logic          sample_ack_q, dmem_wr_q, mul_en_q, norm_en_q, valid_q, busy_q, first_tap_q;
    logic [AW-1:0] dmem_addr_q, cmem_addr_q;

    logic [PIPE_LAT-1:0] en_pipe_q;
    logic [PIPE_LAT-1:0] clr_pipe_q;

    // State, head pointer, tap/drain counter and latched tap count
    always_ff @(posedge clk2) begin
        if (rst) begin
            state_q  <= IDLE;
            head_q   <= '0;
            k_q      <= '0;
            n_last_q <= TAP_LAST;
        end else begin
            state_q  <= state_d;
            head_q   <= head_d;
            k_q      <= k_d;
            n_last_q <= n_last_d;
        end
    end

    // Next state, then output values decoded from the next state so outputs can be registered
    always_comb begin
        state_d  = state_q;
        head_d   = head_q;
        k_d      = k_q;
        n_last_d = n_last_q;

        unique case (state_q)
            IDLE: begin
                if (bus.sample_req) begin
                    state_d = LOAD;
                    if (bus.ntaps == 7'd0 || bus.ntaps > 7'(NTAPS_MAX)) begin
                        n_last_d = TAP_LAST;
                    end else begin
                        n_last_d = AW'(bus.ntaps - 7'd1);
                    end
                end
            end
            LOAD: begin
                state_d = MAC;
                k_d     = '0;
            end
            MAC: begin
                if (k_q == n_last_q) begin
                    state_d = DRAIN;
                    k_d     = '0;
                end else begin
                    k_d = k_q + AW'(1);
                end
            end
            DRAIN: begin
                if (k_q == DRAIN_LAST) begin
                    state_d = NORM;
                    k_d     = '0;
                end else begin
                    k_d = k_q + AW'(1);
                end
            end
            NORM: begin
                state_d = IDLE;
                head_d  = head_q + AW'(1);
            end
            default: begin
                state_d = IDLE;
                k_d     = '0;
            end
        endcase

        sample_ack_d = (state_d == LOAD);
        dmem_wr_d    = (state_d == LOAD);
        mul_en_d     = (state_d == MAC);
        norm_en_d    = (state_d == NORM);
        busy_d       = (state_d != IDLE);
        valid_d      = (state_q == NORM);
        first_tap_d  = mul_en_d && (k_d == '0);

        dmem_addr_d = '0;
        if (state_d == LOAD) begin
            dmem_addr_d = head_d;
        end else if (state_d == MAC) begin
            dmem_addr_d = head_d - k_d;
        end
        cmem_addr_d = mul_en_d ? k_d : '0;
    end

    // Output registers and the accumulator-enable delay line
    always_ff @(posedge clk2) begin
        if (rst) begin
            sample_ack_q <= 1'b0;
            dmem_wr_q    <= 1'b0;
            mul_en_q     <= 1'b0;
            norm_en_q    <= 1'b0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            first_tap_q  <= 1'b0;
            dmem_addr_q  <= '0;
            cmem_addr_q  <= '0;
            en_pipe_q    <= '0;
            clr_pipe_q   <= '0;
        end else begin
            sample_ack_q <= sample_ack_d;
            dmem_wr_q    <= dmem_wr_d;
            mul_en_q     <= mul_en_d;
            norm_en_q    <= norm_en_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
            first_tap_q  <= first_tap_d;
            dmem_addr_q  <= dmem_addr_d;
            cmem_addr_q  <= cmem_addr_d;
            en_pipe_q    <= PIPE_LAT'({en_pipe_q, mul_en_q});
            clr_pipe_q   <= PIPE_LAT'({clr_pipe_q, first_tap_q});
        end
    end

    assign bus.sample_ack = sample_ack_q;
    assign bus.dmem_wr    = dmem_wr_q;
    assign bus.dmem_addr  = dmem_addr_q;
    assign bus.cmem_addr  = cmem_addr_q;
    assign bus.mul_en     = mul_en_q;
    assign bus.acc_en     = en_pipe_q[PIPE_LAT-1];
    assign bus.acc_clr    = clr_pipe_q[PIPE_LAT-1];
    assign bus.norm_en    = norm_en_q;
    assign bus.valid      = valid_q;
    assign bus.busy       = busy_q;

    // Sample request takes priority over a coefficient-load grant in the same cycle
    assign bus.cload_gnt = (state_q == IDLE) && bus.cload && !bus.sample_req;

`ifdef FIR_SEQ_DROP_CNT_EN
    logic drop_c;
    assign drop_c = bus.sample_req && (state_q != IDLE);

    always_ff @(posedge clk2) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (drop_c && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`else
    // Requests arriving while busy are discarded without a trace.
`endif

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Directed self-checking bench for fir_seq_ctrl (PIPE_LAT = 5).
module tb_fir_seq_ctrl;

    logic clk2;
    logic rst;
    int   total;
    int   bad;
`ifdef FIR_SEQ_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    fir_seq_ctrl_if bus ();

    fir_seq_ctrl #(.PIPE_LAT(5)) dut (
        .clk2     (clk2),
        .rst      (rst),
`ifdef FIR_SEQ_DROP_CNT_EN
        .drop_cnt (drop_cnt),
`endif
        .bus      (bus)
    );

    initial clk2 = 1'b0;
    always #5 clk2 = ~clk2;

    task automatic step();
        @(posedge clk2);
        #1;
    endtask

    // {sample_ack, dmem_wr, mul_en, acc_en, acc_clr, norm_en, valid, busy}
    function automatic logic [7:0] flags();
        return {bus.sample_ack, bus.dmem_wr, bus.mul_en, bus.acc_en,
                bus.acc_clr, bus.norm_en, bus.valid, bus.busy};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        total++;
        if (flags() !== 8'h00) begin
            bad++; $display("FAIL reset_flags got=%b exp=%b", flags(), 8'h00);
        end
        total++;
        if ({bus.dmem_addr, bus.cmem_addr, bus.cload_gnt} !== 13'd0) begin
            bad++; $display("FAIL reset_addr got=%h/%h/%b exp=0/0/0", bus.dmem_addr, bus.cmem_addr, bus.cload_gnt);
        end
        rst = 1'b0;
        step();
        bus.cload = 1'b1;
        #1;
        total++;
        if (bus.cload_gnt !== 1'b1) begin
            bad++; $display("FAIL idle_gnt got=%b exp=1", bus.cload_gnt);
        end
        bus.cload = 1'b0;
        #1;
        total++;
        if (bus.cload_gnt !== 1'b0) begin
            bad++; $display("FAIL idle_gnt_release got=%b exp=0", bus.cload_gnt);
        end
    endtask

    task automatic test_basic();
        logic [7:0] exp_f;
        logic [5:0] exp_d;
        logic [5:0] exp_c;
        bus.ntaps      = 7'd4;
        bus.sample_req = 1'b1;
        for (int t = 1; t <= 13; t++) begin
            step();
            if (t == 1) bus.sample_req = 1'b0;
            if (t == 3) bus.ntaps = 7'd20;
            exp_f = {(t == 1), (t == 1), (t >= 2 && t <= 5), (t >= 7 && t <= 10),
                     (t == 7), (t == 11), (t == 12), (t >= 1 && t <= 11)};
            case (t)
                3:       exp_d = 6'd63;
                4:       exp_d = 6'd62;
                5:       exp_d = 6'd61;
                default: exp_d = 6'd0;
            endcase
            exp_c = (t >= 2 && t <= 5) ? 6'(t - 2) : 6'd0;
            total++;
            if (flags() !== exp_f) begin
                bad++; $display("FAIL basic_flags t=%0d got=%b exp=%b", t, flags(), exp_f);
            end
            total++;
            if (bus.dmem_addr !== exp_d) begin
                bad++; $display("FAIL basic_dmem t=%0d got=%0d exp=%0d", t, bus.dmem_addr, exp_d);
            end
            total++;
            if (bus.cmem_addr !== exp_c) begin
                bad++; $display("FAIL basic_cmem t=%0d got=%0d exp=%0d", t, bus.cmem_addr, exp_c);
            end
        end
    endtask

    task automatic test_ntaps_clamp();
        int   mul_cnt;
        int   vt;
        logic seen;
        for (int r = 0; r < 2; r++) begin
            bus.ntaps      = (r == 0) ? 7'd0 : 7'd100;
            bus.sample_req = 1'b1;
            mul_cnt = 0;
            vt      = 0;
            seen    = 1'b0;
            for (int t = 1; t <= 150 && !seen; t++) begin
                step();
                if (t == 1) bus.sample_req = 1'b0;
                if (bus.mul_en) begin
                    total++;
                    if (bus.cmem_addr !== 6'(mul_cnt)) begin
                        bad++; $display("FAIL clamp_cmem run=%0d got=%0d exp=%0d", r, bus.cmem_addr, mul_cnt);
                    end
                    mul_cnt++;
                end
                if (bus.valid) begin
                    seen = 1'b1;
                    vt   = t;
                end
            end
            total++;
            if (mul_cnt != 64) begin
                bad++; $display("FAIL clamp_mul_count run=%0d got=%0d exp=64", r, mul_cnt);
            end
            total++;
            if (vt != 72) begin
                bad++; $display("FAIL clamp_valid_latency run=%0d got=%0d exp=72", r, vt);
            end
        end
    endtask

    task automatic test_cload();
        logic seen;
        int   vt;
        bus.ntaps      = 7'd2;
        bus.cload      = 1'b1;
        bus.sample_req = 1'b1;
        #1;
        total++;
        if (bus.cload_gnt !== 1'b0) begin
            bad++; $display("FAIL cload_vs_req got=%b exp=0", bus.cload_gnt);
        end
        step();
        bus.sample_req = 1'b0;
        total++;
        if ({bus.sample_ack, bus.cload_gnt} !== 2'b10) begin
            bad++; $display("FAIL cload_ack got=%b exp=10", {bus.sample_ack, bus.cload_gnt});
        end
        seen = 1'b0;
        vt   = 0;
        for (int t = 2; t <= 40 && !seen; t++) begin
            step();
            total++;
            if (bus.valid) begin
                seen = 1'b1;
                vt   = t;
                if (bus.cload_gnt !== 1'b1) begin
                    bad++; $display("FAIL cload_gnt_after_valid got=%b exp=1", bus.cload_gnt);
                end
            end else if (bus.cload_gnt !== 1'b0) begin
                bad++; $display("FAIL cload_gnt_busy t=%0d got=%b exp=0", t, bus.cload_gnt);
            end
        end
        total++;
        if (vt != 10) begin
            bad++; $display("FAIL cload_valid_latency got=%0d exp=10", vt);
        end
        bus.cload = 1'b0;
    endtask

    task automatic test_drop();
        int t;
        int mul_cnt;
        int ack_cnt;
        int vt;
        bus.ntaps      = 7'd8;
        bus.sample_req = 1'b1;
        step();
        bus.sample_req = 1'b0;
        t = 1;
        total++;
        if (bus.sample_ack !== 1'b1) begin
            bad++; $display("FAIL drop_first_ack got=%b exp=1", bus.sample_ack);
        end
        mul_cnt = 0;
        ack_cnt = 0;
        vt      = 0;
        for (int p = 0; p < 3; p++) begin
            step(); t++;
            if (bus.mul_en) mul_cnt++;
            bus.sample_req = 1'b1;
            step(); t++;
            bus.sample_req = 1'b0;
            if (bus.mul_en) mul_cnt++;
            if (bus.sample_ack) ack_cnt++;
        end
        while (vt == 0 && t < 60) begin
            step(); t++;
            if (bus.mul_en) mul_cnt++;
            if (bus.sample_ack) ack_cnt++;
            if (bus.valid) vt = t;
        end
        total++;
        if (ack_cnt != 0) begin
            bad++; $display("FAIL drop_ack_count got=%0d exp=0", ack_cnt);
        end
        total++;
        if (mul_cnt != 8) begin
            bad++; $display("FAIL drop_mul_count got=%0d exp=8", mul_cnt);
        end
        total++;
        if (vt != 16) begin
            bad++; $display("FAIL drop_valid_latency got=%0d exp=16", vt);
        end
        repeat (4) begin
            step();
            total++;
            if (flags() !== 8'h00) begin
                bad++; $display("FAIL drop_no_replay got=%b exp=%b", flags(), 8'h00);
            end
        end
`ifdef FIR_SEQ_DROP_CNT_EN
        total++;
        if (drop_cnt !== 8'd3) begin
            bad++; $display("FAIL drop_cnt got=%0d exp=3", drop_cnt);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic       seen;
        logic [5:0] last_addr;
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.ntaps = 7'd1;
        last_addr = 6'h3F;
        for (int i = 0; i < 65; i++) begin
            bus.sample_req = 1'b1;
            step();
            bus.sample_req = 1'b0;
            total++;
            if ({bus.dmem_wr, bus.dmem_addr} !== {1'b1, 6'(i)}) begin
                bad++; $display("FAIL wrap_write i=%0d got=%b/%0d exp=1/%0d", i, bus.dmem_wr, bus.dmem_addr, i % 64);
            end
            if (i == 64) last_addr = bus.dmem_addr;
            seen = 1'b0;
            for (int c = 0; c < 20 && !seen; c++) begin
                step();
                if (bus.valid) seen = 1'b1;
            end
            total++;
            if (!seen) begin
                bad++; $display("FAIL wrap_valid_timeout i=%0d got=0 exp=1", i);
            end
        end
        total++;
        if (last_addr !== 6'd0) begin
            bad++; $display("FAIL wrap_65th_addr got=%0d exp=0", last_addr);
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        logic stray;
        bus.ntaps      = 7'd4;
        bus.sample_req = 1'b1;
        step();
        bus.sample_req = 1'b0;
        repeat (6) step();
        total++;
        if ({bus.acc_en, bus.busy, bus.mul_en} !== 3'b110) begin
            bad++; $display("FAIL midrst_in_drain got=%b exp=110", {bus.acc_en, bus.busy, bus.mul_en});
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if (flags() !== 8'h00) begin
            bad++; $display("FAIL midrst_flags got=%b exp=%b", flags(), 8'h00);
        end
        total++;
        if ({bus.dmem_addr, bus.cmem_addr} !== 12'd0) begin
            bad++; $display("FAIL midrst_addr got=%0d/%0d exp=0/0", bus.dmem_addr, bus.cmem_addr);
        end
        stray = 1'b0;
        repeat (8) begin
            step();
            if (bus.valid || bus.busy) stray = 1'b1;
        end
        total++;
        if (stray !== 1'b0) begin
            bad++; $display("FAIL midrst_stray_activity got=%b exp=0", stray);
        end
        bus.ntaps      = 7'd2;
        bus.sample_req = 1'b1;
        step();
        bus.sample_req = 1'b0;
        total++;
        if ({bus.dmem_wr, bus.dmem_addr} !== 7'b1_000000) begin
            bad++; $display("FAIL midrst_next_write got=%b/%0d exp=1/0", bus.dmem_wr, bus.dmem_addr);
        end
        seen = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            step();
            if (bus.valid) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            bad++; $display("FAIL midrst_valid_timeout got=0 exp=1");
        end
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        rst            = 1'b1;
        bus.sample_req = 1'b0;
        bus.ntaps      = 7'd0;
        bus.cload      = 1'b0;
        test_reset();
        test_basic();
        test_ntaps_clamp();
        test_cload();
        test_drop();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
